sp_core_seq: RTL and testbench

//  Parametrised, self-sequencing streaming-processor core: successor to the hand-sequenced SPCore.

---
 rtl/sp_core_seq.sv | 195 +++++++++++++++++++
 tb/tb_sp_core_seq.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sp_core_seq.sv
// Self-sequencing streaming-processor lane core: accepts one decoded instruction per handshake,
// runs EXE, an optional multi-cycle MUL phase, then WB, with predication and illegal-op reporting.
module sp_core_seq #(
  parameter int DATA_W  = 16,
  parameter int N_REGS  = 16,
  parameter int CORE_ID = 0,
  parameter int N_CORES = 1,
  parameter int MUL_LAT = 2,
  localparam int RA_W   = $clog2(N_REGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_op,
  input  logic [RA_W-1:0]   cmd_x,
  input  logic [RA_W-1:0]   cmd_y,
  input  logic [RA_W-1:0]   cmd_z,
  input  logic [DATA_W-1:0] cmd_imm,
  input  logic              cmd_pred,
  output logic              done,
  output logic              done_wr,
  output logic [DATA_W-1:0] result,
  output logic              err,
  output logic              p_out,
  input  logic [RA_W-1:0]   dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int CNT_W = $clog2(MUL_LAT + 1);

  localparam logic [3:0] OP_CLEAR   = 4'd0;
  localparam logic [3:0] OP_LOADI   = 4'd1;
  localparam logic [3:0] OP_ADD     = 4'd2;
  localparam logic [3:0] OP_MUL     = 4'd3;
  localparam logic [3:0] OP_MAD     = 4'd4;
  localparam logic [3:0] OP_INC     = 4'd5;
  localparam logic [3:0] OP_LOADC   = 4'd6;
  localparam logic [3:0] OP_LOADN   = 4'd7;
  localparam logic [3:0] OP_SETP_EQ = 4'd8;
  localparam logic [3:0] OP_SETP_LT = 4'd9;

  typedef enum logic [1:0] {S_IDLE, S_EXE, S_MUL, S_WB} state_t;

  state_t              state_q, state_d;
  logic [3:0]          op_q, op_d;
  logic [RA_W-1:0]     x_q, x_d, y_q, y_d, z_q, z_d;
  logic [DATA_W-1:0]   imm_q, imm_d;
  logic                pred_q, pred_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   res_q, res_d;
  logic                wr_q, wr_d;
  logic                setp_q, setp_d;
  logic                err_q, err_d;
  logic                p_q, p_d;
  logic [DATA_W-1:0]   regs_q [N_REGS];
  logic [DATA_W-1:0]   regs_d [N_REGS];

  logic [DATA_W-1:0]   rx, ry, rz;

  // Product truncated to the datapath width before any accumulate.
  function automatic logic [DATA_W-1:0] mul_lo(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
    logic [2*DATA_W-1:0] prod;
    prod = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
    return prod[DATA_W-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] flag_word(input logic f);
    return {{(DATA_W-1){1'b0}}, f};
  endfunction

  assign rx = regs_q[x_q];
  assign ry = regs_q[y_q];
  assign rz = regs_q[z_q];

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    imm_d   = imm_q;
    pred_d  = pred_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    wr_d    = wr_q;
    setp_d  = setp_q;
    err_d   = err_q;
    p_d     = p_q;
    regs_d  = regs_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d    = cmd_op;
          x_d     = cmd_x;
          y_d     = cmd_y;
          z_d     = cmd_z;
          imm_d   = cmd_imm;
          pred_d  = cmd_pred;
          state_d = S_EXE;
        end
      end

      S_EXE: begin
        res_d  = '0;
        wr_d   = 1'b0;
        setp_d = 1'b0;
        err_d  = 1'b0;
        // Squashed instructions still retire, but leave registers and P untouched.
        if (op_q > OP_SETP_LT) begin
          err_d = 1'b1;
        end else if (!(pred_q && !p_q)) begin
          case (op_q)
            OP_CLEAR:   begin res_d = '0;                     wr_d = 1'b1; end
            OP_LOADI:   begin res_d = imm_q;                  wr_d = 1'b1; end
            OP_ADD:     begin res_d = ry + rz;                wr_d = 1'b1; end
            OP_MUL:     begin res_d = mul_lo(ry, rz);         wr_d = 1'b1; end
            OP_MAD:     begin res_d = rx + mul_lo(ry, rz);    wr_d = 1'b1; end
            OP_INC:     begin res_d = rx + DATA_W'(1);        wr_d = 1'b1; end
            OP_LOADC:   begin res_d = DATA_W'(CORE_ID);       wr_d = 1'b1; end
            OP_LOADN:   begin res_d = DATA_W'(N_CORES);       wr_d = 1'b1; end
            OP_SETP_EQ: begin res_d = flag_word(rx == ry);    setp_d = 1'b1; end
            OP_SETP_LT: begin res_d = flag_word(rx < ry);     setp_d = 1'b1; end
            default:    ;
          endcase
        end
        if (op_q == OP_MUL || op_q == OP_MAD) begin
          cnt_d   = CNT_W'(MUL_LAT - 1);
          state_d = S_MUL;
        end else begin
          state_d = S_WB;
        end
      end

      S_MUL: begin
        if (cnt_q == '0) state_d = S_WB;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end

      S_WB: begin
        if (wr_q)   regs_d[x_q] = res_q;
        if (setp_q) p_d         = res_q[0];
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      imm_q   <= '0;
      pred_q  <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      wr_q    <= 1'b0;
      setp_q  <= 1'b0;
      err_q   <= 1'b0;
      p_q     <= 1'b0;
      for (int i = 0; i < N_REGS; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      imm_q   <= imm_d;
      pred_q  <= pred_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      wr_q    <= wr_d;
      setp_q  <= setp_d;
      err_q   <= err_d;
      p_q     <= p_d;
      regs_q  <= regs_d;
    end
  end

  // Retirement outputs are qualified by WB so they read zero in every other state.
  assign cmd_ready = (state_q == S_IDLE) && reset;
  assign done      = (state_q == S_WB);
  assign done_wr   = done && wr_q;
  assign err       = done && err_q;
  assign result    = done ? res_q : '0;
  assign p_out     = p_q;
  assign dbg_data  = regs_q[dbg_addr];

endmodule

// File: tb/tb_sp_core_seq.sv
// Randomized scoreboard bench for sp_core_seq: driver predicts each retirement from a plain
// arithmetic model; an independent monitor pops and checks whenever done pulses.
module tb_sp_core_seq;
  localparam int DW  = 16;
  localparam int NR  = 16;
  localparam int RAW = 4;
  localparam int CID = 100;
  localparam int NC  = 200;
  localparam int ML  = 2;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           cmd_valid = 1'b0;
  logic           cmd_ready;
  logic [3:0]     cmd_op = '0;
  logic [RAW-1:0] cmd_x = '0, cmd_y = '0, cmd_z = '0;
  logic [DW-1:0]  cmd_imm = '0;
  logic           cmd_pred = 1'b0;
  logic           done, done_wr, err, p_out;
  logic [DW-1:0]  result;
  logic [RAW-1:0] dbg_addr = '0;
  logic [DW-1:0]  dbg_data;

  always #5 clk = ~clk;

  sp_core_seq #(.DATA_W(DW), .N_REGS(NR), .CORE_ID(CID), .N_CORES(NC), .MUL_LAT(ML)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_z(cmd_z), .cmd_imm(cmd_imm),
    .cmd_pred(cmd_pred), .done(done), .done_wr(done_wr), .result(result), .err(err),
    .p_out(p_out), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  typedef struct {
    bit wr;
    int res;
    bit chk_res;
    bit er;
    int lat;
    int acc;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   mr[NR];
  bit   mp;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Monitor: latency is counted in edges from the accept edge to the edge that enters WB;
  // WB itself ends one edge later.
  always @(negedge clk) begin
    if (reset) begin
      if (done) begin
        if (sbq.size() == 0) begin
          chk("unexpected_done", 32'(sbq.size()), 1);
        end else begin
          mon_e = sbq.pop_front();
          chk("done_wr", done_wr, mon_e.wr);
          chk("err", err, mon_e.er);
          if (mon_e.chk_res) chk("result", result, mon_e.res);
          chk("latency", cyc - mon_e.acc, mon_e.lat);
        end
      end else begin
        chk("idle_outputs", {err, done_wr, result}, 0);
      end
    end
  end

  task automatic model_clear();
    for (int i = 0; i < NR; i++) mr[i] = 0;
    mp = 1'b0;
  endtask

  task automatic issue(input int op, input int x, input int y, input int z,
                       input int imm, input bit pred);
    exp_t e;
    int   g;
    g = 0;
    @(negedge clk);
    while (!cmd_ready && g < 50) begin
      g++;
      @(negedge clk);
    end
    if (!cmd_ready) begin
      chk("issue_ready", cmd_ready, 1);
      return;
    end
    cmd_valid = 1'b1;
    cmd_op    = 4'(op);
    cmd_x     = RAW'(x);
    cmd_y     = RAW'(y);
    cmd_z     = RAW'(z);
    cmd_imm   = DW'(imm);
    cmd_pred  = pred;
    e.acc     = cyc + 1;
    e.lat     = (op == 3 || op == 4) ? 1 + ML : 1;
    e.wr      = 1'b0;
    e.res     = 0;
    e.er      = 1'b0;
    e.chk_res = 1'b1;
    if (op > 9) begin
      e.er = 1'b1;
    end else if (pred && !mp) begin
      e.chk_res = 1'b0;
    end else begin
      case (op)
        0: begin e.wr = 1; e.res = 0; end
        1: begin e.wr = 1; e.res = imm & 'hFFFF; end
        2: begin e.wr = 1; e.res = (mr[y] + mr[z]) % 65536; end
        3: begin e.wr = 1; e.res = (mr[y] * mr[z]) & 'hFFFF; end
        4: begin e.wr = 1; e.res = (mr[x] + ((mr[y] * mr[z]) & 'hFFFF)) % 65536; end
        5: begin e.wr = 1; e.res = (mr[x] + 1) % 65536; end
        6: begin e.wr = 1; e.res = CID % 65536; end
        7: begin e.wr = 1; e.res = NC % 65536; end
        8: e.res = (mr[x] == mr[y]) ? 1 : 0;
        default: e.res = (mr[x] < mr[y]) ? 1 : 0;
      endcase
      if (e.wr) mr[x] = e.res;
      else      mp = (e.res != 0);
    end
    sbq.push_back(e);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    @(negedge clk);
    while (!cmd_ready && g < 50) begin
      g++;
      @(negedge clk);
    end
    chk("ready_wait", cmd_ready, 1);
  endtask

  task automatic check_reg(input string name, input int r, input int expv);
    dbg_addr = RAW'(r);
    #1 chk(name, dbg_data, expv);
  endtask

  task automatic sweep_regs(input string name);
    for (int i = 0; i < NR; i++) check_reg(name, i, mr[i]);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int op, x;
    model_clear();
    // Reset held low: core must not advertise readiness.
    repeat (3) @(negedge clk);
    chk("ready_in_reset", cmd_ready, 0);
    chk("done_in_reset", done, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", cmd_ready, 1);
    chk("p_after_reset", p_out, 0);
    sweep_regs("reg_after_reset");

    // Basic load/add and multiply paths with fixed expected values.
    issue(1, 0, 0, 0, 11, 0);
    issue(1, 1, 0, 0, 20, 0);
    issue(2, 2, 0, 1, 0, 0);
    wait_idle();
    check_reg("add_r2", 2, 31);
    issue(4, 2, 0, 1, 0, 0);
    wait_idle();
    check_reg("mad_r2", 2, 251);
    issue(1, 6, 0, 0, 300, 0);
    issue(1, 7, 0, 0, 300, 0);
    issue(3, 8, 6, 7, 0, 0);
    wait_idle();
    check_reg("mul_wrap_r8", 8, 24464);

    issue(6, 3, 0, 0, 0, 0);
    wait_idle();
    check_reg("loadc_r3", 3, 100);
    issue(7, 4, 0, 0, 0, 0);
    wait_idle();
    check_reg("loadn_r4", 4, 200);
    issue(0, 3, 0, 0, 0, 0);
    wait_idle();
    check_reg("clear_r3", 3, 0);
    issue(5, 3, 0, 0, 0, 0);
    wait_idle();
    check_reg("inc_r3", 3, 1);

    // Predicate set, predicated execute, predicate clear, predicated squash.
    issue(8, 1, 1, 0, 0, 0);
    wait_idle();
    chk("setp_eq_p", p_out, 1);
    issue(2, 9, 0, 1, 0, 1);
    wait_idle();
    check_reg("pred_add_r9", 9, 31);
    issue(9, 1, 0, 0, 0, 0);
    wait_idle();
    chk("setp_lt_p", p_out, 0);
    issue(1, 5, 0, 0, 7, 1);
    wait_idle();
    check_reg("squash_r5", 5, 0);

    // Illegal opcode, then a MUL during which cmd_valid toggles with a competing LOADI.
    issue(12, 2, 0, 0, 0, 0);
    wait_idle();
    check_reg("illegal_r2", 2, 251);
    chk("illegal_p", p_out, 0);
    issue(3, 10, 0, 1, 0, 0);
    cmd_op = 4'd1; cmd_x = 4'd5; cmd_imm = 16'd999; cmd_pred = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      cmd_valid = (i != 1);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_idle();
    check_reg("busy_ignored_r5", 5, 0);
    check_reg("mul_r10", 10, 220);

    // Reset asserted while in the MUL phase aborts the instruction.
    issue(3, 11, 0, 1, 0, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    sbq.delete();
    model_clear();
    @(negedge clk);
    chk("ready_mid_reset", cmd_ready, 0);
    chk("done_mid_reset", done, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("ready_post_abort", cmd_ready, 1);
    chk("p_post_abort", p_out, 0);
    sweep_regs("reg_post_abort");

    // Randomized instruction stream against the model.
    for (int n = 0; n < 200; n++) begin
      op = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 9));
      x  = int'($urandom_range(0, NR - 1));
      issue(op, x, int'($urandom_range(0, NR - 1)), int'($urandom_range(0, NR - 1)),
            int'($urandom_range(0, 65535)), ($urandom_range(0, 2) == 0));
      wait_idle();
      chk("rand_p", p_out, mp);
      check_reg("rand_rx", x, mr[x]);
    end
    sweep_regs("final_regs");

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", 32'(sbq.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
